// File: rtl/demux_1x2_buf.sv
// One valid/ready source steered per beat into two independently buffered sinks.
// Each destination owns a small FIFO so a stalled sink never blocks the other.
module demux_1x2_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out0_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [DATA_WIDTH-1:0]      out1_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [$clog2(DEPTH):0]     count0,
    output logic [$clog2(DEPTH):0]     count1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]                 full;
    logic [1:0]                 out_ready;
    logic [1:0]                 out_valid;
    logic [1:0][DATA_WIDTH-1:0] head_data;
    logic [1:0][CW-1:0]         count;
    logic                       accept;

    // Ready looks only at the selected FIFO's full flag, never at a same-cycle pop.
    assign in_ready  = ~rst & (in_sel ? ~full[1] : ~full[0]);
    assign accept    = in_valid & in_ready;
    assign out_ready = {out1_ready, out0_ready};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_WIDTH-1:0] mem_q [DEPTH];
            logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
            logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]         count_q, count_d;
            logic                  push, pop;

            assign push = accept & (in_sel == 1'(gi));
            assign pop  = out_valid[gi] & out_ready[gi];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                    if (push) begin
                        mem_q[wr_ptr_q] <= in_data;
                    end
                end
            end

            assign full[gi]      = (count_q == CW'(DEPTH));
            assign out_valid[gi] = (count_q != '0);
            assign head_data[gi] = mem_q[rd_ptr_q];
            assign count[gi]     = count_q;
        end
    endgenerate

    assign out0_data  = head_data[0];
    assign out1_data  = head_data[1];
    assign out0_valid = out_valid[0];
    assign out1_valid = out_valid[1];
    assign count0     = count[0];
    assign count1     = count[1];

endmodule

// File: tb/tb_demux_1x2_buf.sv
// Directed bench for demux_1x2_buf: reset, steering, backpressure, full+pop, wrap, mid-stream reset.
module tb_demux_1x2_buf;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out0_data;
    logic          out0_valid;
    logic          out0_ready;
    logic [DW-1:0] out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [1:0]    count0;
    logic [1:0]    count1;

    int checks = 0;
    int errors = 0;

    demux_1x2_buf #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count0     (count0),
        .count1     (count1)
    );

    always #5 clk = ~clk;

    // Inputs are driven at the falling edge; one line per transfer taken at the next rising edge.
    task automatic tick();
        if (in_valid && in_ready)
            $display("push  sel=%0d data=%h", in_sel, in_data);
        if (out0_valid && out0_ready)
            $display("pop0  data=%h", out0_data);
        if (out1_valid && out1_ready)
            $display("pop1  data=%h", out1_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1234;
        out0_ready = 1'b0; out1_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b%b exp 00", out1_valid, out0_valid); end
        checks++; if (out0_data !== 16'h0 || out1_data !== 16'h0) begin errors++; $display("FAIL rst_data got %h %h exp 0000 0000", out0_data, out1_data); end
        checks++; if (count0 !== 2'd0 || count1 !== 2'd0) begin errors++; $display("FAIL rst_count got %0d %0d exp 0 0", count0, count1); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (count0 !== 2'd1 || out0_data !== 16'h1234) begin errors++; $display("FAIL first_beat got cnt %0d data %h exp 1 1234", count0, out0_data); end
        in_valid = 1'b0; out0_ready = 1'b1;
        tick();
        checks++; if (count0 !== 2'd0) begin errors++; $display("FAIL drain0 got %0d exp 0", count0); end
        out0_ready = 1'b0;
    endtask

    task automatic test_steering();
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1111;
        tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 16'h1111) begin errors++; $display("FAIL steer_out0 got v%b %h exp v1 1111", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL steer_out1_idle got %b exp 0", out1_valid); end
        in_sel = 1'b1; in_data = 16'h2222;
        tick();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 16'h2222) begin errors++; $display("FAIL steer_out1 got v%b %h exp v1 2222", out1_valid, out1_data); end
        checks++; if (count0 !== 2'd0 || out0_valid !== 1'b0) begin errors++; $display("FAIL steer_pop0 got cnt %0d v%b exp 0 v0", count0, out0_valid); end
        in_valid = 1'b0;
        tick();
        checks++; if (count0 !== 2'd0 || count1 !== 2'd0) begin errors++; $display("FAIL steer_counts got %0d %0d exp 0 0", count0, count1); end
    endtask

    task automatic test_idle();
        // No valid: nothing is pushed; ready on empty outputs changes nothing.
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        in_sel = 1'b0; in_data = 16'hDEAD;
        tick();
        in_sel = 1'b1; in_data = 16'hBEEF;
        tick();
        checks++; if (count0 !== 2'd0 || count1 !== 2'd0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL idle got cnt %0d %0d exp 0 0", count0, count1); end
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h00A0;
        tick();
        in_data = 16'h00A1;
        tick();
        checks++; if (count0 !== 2'd2) begin errors++; $display("FAIL bp_count0 got %0d exp 2", count0); end
        in_data = 16'h00A2;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_sel0 got %b exp 0", in_ready); end
        in_sel = 1'b1; in_data = 16'h00B0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_sel1 got %b exp 1", in_ready); end
        tick();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 16'h00B0) begin errors++; $display("FAIL bp_out1 got v%b %h exp v1 00b0", out1_valid, out1_data); end
        checks++; if (out0_data !== 16'h00A0 || count0 !== 2'd2) begin errors++; $display("FAIL bp_out0_hold got %h cnt %0d exp 00a0 2", out0_data, count0); end
        in_valid = 1'b0; out1_ready = 1'b1;
        tick();
        checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL bp_drain1 got %0d exp 0", count1); end
        out1_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        // FIFO0 still holds A0,A1 from the backpressure scenario.
        out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h00A2;
        #1;
        checks++; if (in_ready !== 1'b0 || out0_data !== 16'h00A0) begin errors++; $display("FAIL fp_reject got rdy %b %h exp 0 00a0", in_ready, out0_data); end
        tick();
        checks++; if (count0 !== 2'd1 || out0_data !== 16'h00A1 || in_ready !== 1'b1) begin errors++; $display("FAIL fp_after_pop got cnt %0d %h rdy %b exp 1 00a1 1", count0, out0_data, in_ready); end
        tick();
        checks++; if (count0 !== 2'd1 || out0_data !== 16'h00A2) begin errors++; $display("FAIL fp_a2 got cnt %0d %h exp 1 00a2", count0, out0_data); end
        in_valid = 1'b0;
        tick();
        checks++; if (count0 !== 2'd0 || out0_valid !== 1'b0) begin errors++; $display("FAIL fp_drain got cnt %0d v%b exp 0 v0", count0, out0_valid); end
        out0_ready = 1'b0;
    endtask

    task automatic test_wrap();
        out1_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'(i);
            tick();
            checks++;
            if (out1_valid !== 1'b1 || out1_data !== 16'(i) || count1 !== 2'd1) begin
                errors++;
                $display("FAIL wrap_beat%0d got v%b %h cnt %0d exp v1 %h 1", i, out1_valid, out1_data, count1, 16'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", count1); end
        out1_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out0_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0011;
        tick();
        in_data = 16'h0022;
        tick();
        checks++; if (count0 !== 2'd2) begin errors++; $display("FAIL mid_fill got %0d exp 2", count0); end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (count0 !== 2'd0 || out0_valid !== 1'b0 || out0_data !== 16'h0) begin errors++; $display("FAIL mid_rst got cnt %0d v%b %h exp 0 v0 0000", count0, out0_valid, out0_data); end
        in_valid = 1'b1; in_data = 16'h0055;
        tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 16'h0055 || count0 !== 2'd1) begin errors++; $display("FAIL mid_new got v%b %h cnt %0d exp v1 0055 1", out0_valid, out0_data, count0); end
        in_valid = 1'b0; out0_ready = 1'b1;
        tick();
        checks++; if (out0_valid !== 1'b0 || count0 !== 2'd0) begin errors++; $display("FAIL mid_no_stale got v%b cnt %0d exp v0 0", out0_valid, count0); end
        out0_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steering();
        test_idle();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1x2_buf.md
Name: demux_1x2_buf

Overview:
- Splits one valid/ready data stream into two destination streams, steered per beat by a select bit.
- It is the sequential counterpart of the 2:1 select path: one source fans out to two consumers instead of two sources merging into one.
- Each destination has its own small FIFO, so a stalled consumer never blocks beats headed to the other consumer.
- Sits between a producer (e.g. a writeback/forwarding source) and two independent sinks in the MIPS datapath.

Parameters:
- DATA_WIDTH, 16, width of every data bus.
- DEPTH, 2, entries per output FIFO; must be a power of 2 and ≥2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  input beat payload.
- in_sel  input  1  destination of the current beat: 0 = out0, 1 = out1.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  selected FIFO can accept the beat.
- out0_data  output  DATA_WIDTH  head of FIFO 0.
- out0_valid  output  1  FIFO 0 not empty.
- out0_ready  input  1  sink 0 accepts the head.
- out1_data  output  DATA_WIDTH  head of FIFO 1.
- out1_valid  output  1  FIFO 1 not empty.
- out1_ready  input  1  sink 1 accepts the head.
- count0  output  $clog2(DEPTH)+1  occupancy of FIFO 0.
- count1  output  $clog2(DEPTH)+1  occupancy of FIFO 1.

Behaviour:
- Reset (rst high at a clock edge):
  - Read/write pointers and counts clear to 0.
  - Storage clears to 0.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0; count0 = count1 = 0.
  - Reset mid-operation discards all buffered beats. The cycle after reset deasserts behaves as empty.
- in_ready is combinational: in_ready = (in_sel ? ~full1 : ~full0).
  - It depends only on the selected FIFO's current full flag, never on the same-cycle pop.
  - in_ready is 0 whenever rst = 1.
- Push: occurs when in_valid & in_ready at a clock edge.
  - in_data is written at the write pointer of FIFO[in_sel]; that pointer increments modulo DEPTH.
  - Producer may change in_sel while in_valid is held and not yet accepted; in_ready tracks the new in_sel in the same cycle.
- Pop on output k: occurs when outk_valid & outk_ready at a clock edge; the read pointer increments modulo DEPTH.
- Outputs are read directly from storage:
  - outk_data = mem_k[rd_ptr_k]; outk_valid = (countk != 0).
  - outk_data is stable while outk_valid & ~outk_ready.
- Latency: a beat pushed at edge N appears on outk at cycle N+1 if the FIFO was empty. There is no combinational in→out path.
- Count update per FIFO:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same edge: unchanged, and both pointers advance.
  - full = (count == DEPTH); empty = (count == 0).
- Boundary cases:
  - Full FIFO with pop in the same cycle: no push is accepted that cycle (in_ready = 0 because full). The slot becomes available next cycle.
  - Empty FIFO with push: no pop is possible (valid = 0). The beat is visible next cycle.
  - Pointer wrap: rd/wr pointers wrap from DEPTH−1 to 0 with no loss.
  - Per-output ordering is preserved. No ordering is guaranteed between out0 and out1.
  - Both outputs may pop in the same cycle as one push to either FIFO.
  - outk_ready asserted while outk_valid = 0 has no effect.
  - in_valid = 0 causes no push regardless of in_sel/in_data.
- No state machine beyond the two independent FIFO pointer/count sets.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with in_valid=1 → in_ready=0, both valids 0, data 0, counts 0. After release, the first beat is accepted.
2. Steering/latency: push 0x1111 (sel 0), then 0x2222 (sel 1), both readies=1 → out0 shows 0x1111 one cycle after its push, out1 shows 0x2222 one cycle after its push. Counts return to 0.
3. Backpressure isolation: out0_ready=0; push 0xA0,0xA1 to out0 → count0=2 and in_ready=0 for sel 0. Then push 0xB0 to out1 → accepted, out1 shows 0xB0 while out0 holds 0xA0 stable.
4. Full with simultaneous pop: FIFO0 full (0xA0,0xA1); raise out0_ready and offer 0xA2 same cycle → 0xA2 rejected that cycle, 0xA0 popped, 0xA2 accepted next cycle. out0 sequence is 0xA0,0xA1,0xA2.
5. Wrap and push/pop equal: DEPTH=2, continuous push to out1 with out1_ready=1 for 8 beats 0x00..0x07 → outputs 0x00..0x07 in order, count1 stays 1 after the first beat, with no drops.
6. Reset mid-stream: with count0=2, assert rst one cycle → counts 0, valids 0. Prior data never appears; a new push of 0x55 emerges as the first out0 beat.
